// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo issue/retire datapath.
// Holds the architectural widths, the common-data-bus field layout, the
// "no producer" tag value, the functional-unit codes that form the upper
// field of a reservation-station tag, and a small tag-building helper.
package tomasulo_pkg;

   // Architectural sizes
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int TAG_W    = 8;
   localparam int DATA_W   = 32;

   // Tag layout: {unit[4:0], station[2:0]}
   localparam int UNIT_W   = 5;
   localparam int STN_W    = 3;

   // Common data bus layout: {valid, tag[7:0], value[31:0]}
   localparam int CDB_W       = 41;
   localparam int CDB_VALID   = 40;
   localparam int CDB_TAG_HI  = 39;
   localparam int CDB_TAG_LO  = 32;
   localparam int CDB_DATA_HI = 31;
   localparam int CDB_DATA_LO = 0;

   // Tag value meaning "value is ready, nobody is producing it"
   localparam logic [TAG_W-1:0] TAG_NONE = 8'h00;

   // Functional-unit field codes
   localparam logic [UNIT_W-1:0] UNIT_ALU = 5'b00100;
   localparam logic [UNIT_W-1:0] UNIT_MUL = 5'b01000;
   localparam logic [UNIT_W-1:0] UNIT_DIV = 5'b10000;
   localparam logic [UNIT_W-1:0] UNIT_LS  = 5'b00010;

   // Build a reservation-station tag from a unit code and a station index
   function automatic logic [TAG_W-1:0] make_tag(input logic [UNIT_W-1:0] unit,
                                                 input logic [STN_W-1:0]  idx);
      return {unit, idx};
   endfunction

endpackage

// File: rtl/reg_status_entry.sv
// One architectural register: its result-status tag (Qi) and its value.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cdb_valid/tag/data  decoded common data bus broadcast
//   ren_en, ren_tag   rename this register to ren_tag at the next edge
//   qi_q, val_q       current tag and value
//   qi_d              tag this register will hold after the next edge
// A rename on the same edge as a matching retire keeps the new tag, while the
// value still captures the broadcast the old producer made.
module reg_status_entry
   import tomasulo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              ren_en,
   input  logic [TAG_W-1:0]  ren_tag,
   output logic [TAG_W-1:0]  qi_q,
   output logic [DATA_W-1:0] val_q,
   output logic [TAG_W-1:0]  qi_d
);

   logic              retire_hit_s;
   logic [DATA_W-1:0] val_d;

   // Next-state: retire clears the tag and loads the value, rename overrides the tag
   always_comb begin
      retire_hit_s = cdb_valid && (cdb_tag != TAG_NONE) && (qi_q == cdb_tag);
      qi_d         = qi_q;
      val_d        = val_q;
      if (ren_en) begin
         qi_d = ren_tag;
      end else if (retire_hit_s) begin
         qi_d = TAG_NONE;
      end else begin
         qi_d = qi_q;
      end
      if (retire_hit_s) begin
         val_d = cdb_data;
      end else begin
         val_d = val_q;
      end
   end

   // Tag and value storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qi_q  <= TAG_NONE;
         val_q <= {DATA_W{1'b0}};
      end else begin
         qi_q  <= qi_d;
         val_q <= val_d;
      end
   end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with register result-status (Qi) table.
// Snoops the common data bus to retire results, renames destination
// registers at issue, and supplies operand tag/value pairs to issue.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cdb[40:0]         {valid, tag[7:0], value[31:0]} broadcast
//   issue, issue_rd, issue_tag   rename request
//   rs1_addr, rs2_addr          source register indices
//   q1_out/v1_out, q2_out/v2_out  producer tag (0 = ready) and value
//   busy_count        registered count of registers with a pending producer
// Read ports are combinational and reflect the state before this cycle's
// rename, with a same-cycle bypass of a matching broadcast.
module reg_status_file
   import tomasulo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [CDB_W-1:0]  cdb,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [TAG_W-1:0]  issue_tag,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [TAG_W-1:0]  q1_out,
   output logic [DATA_W-1:0] v1_out,
   output logic [TAG_W-1:0]  q2_out,
   output logic [DATA_W-1:0] v2_out,
   output logic [5:0]        busy_count
);

   logic              cdb_valid_s;
   logic [TAG_W-1:0]  cdb_tag_s;
   logic [DATA_W-1:0] cdb_data_s;
   logic              rename_ok_s;

   logic [TAG_W-1:0]  qi_arr     [NUM_REGS];
   logic [DATA_W-1:0] val_arr    [NUM_REGS];
   logic [TAG_W-1:0]  qi_nxt_arr [NUM_REGS];

   logic [5:0]        busy_d;
   logic [5:0]        busy_q;

   assign cdb_valid_s = cdb[CDB_VALID];
   assign cdb_tag_s   = cdb[CDB_TAG_HI:CDB_TAG_LO];
   assign cdb_data_s  = cdb[CDB_DATA_HI:CDB_DATA_LO];

   // A tag of zero would mark the register ready, so such issues are dropped
   assign rename_ok_s = issue && (issue_rd != 5'd0) && (issue_tag != TAG_NONE);

   // r0 is hardwired to a ready zero
   assign qi_arr[0]     = TAG_NONE;
   assign val_arr[0]    = {DATA_W{1'b0}};
   assign qi_nxt_arr[0] = TAG_NONE;

   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      reg_status_entry u_entry (
         .clk       (clk),
         .rst       (rst),
         .cdb_valid (cdb_valid_s),
         .cdb_tag   (cdb_tag_s),
         .cdb_data  (cdb_data_s),
         .ren_en    (rename_ok_s && (issue_rd == ADDR_W'(gi))),
         .ren_tag   (issue_tag),
         .qi_q      (qi_arr[gi]),
         .val_q     (val_arr[gi]),
         .qi_d      (qi_nxt_arr[gi])
      );
   end

   // Source 1 read port with same-cycle broadcast bypass
   always_comb begin
      q1_out = qi_arr[rs1_addr];
      v1_out = val_arr[rs1_addr];
      if (rs1_addr == 5'd0) begin
         q1_out = TAG_NONE;
         v1_out = {DATA_W{1'b0}};
      end else if ((qi_arr[rs1_addr] != TAG_NONE) && cdb_valid_s &&
                   (cdb_tag_s == qi_arr[rs1_addr])) begin
         q1_out = TAG_NONE;
         v1_out = cdb_data_s;
      end else begin
         q1_out = qi_arr[rs1_addr];
         v1_out = val_arr[rs1_addr];
      end
   end

   // Source 2 read port with same-cycle broadcast bypass
   always_comb begin
      q2_out = qi_arr[rs2_addr];
      v2_out = val_arr[rs2_addr];
      if (rs2_addr == 5'd0) begin
         q2_out = TAG_NONE;
         v2_out = {DATA_W{1'b0}};
      end else if ((qi_arr[rs2_addr] != TAG_NONE) && cdb_valid_s &&
                   (cdb_tag_s == qi_arr[rs2_addr])) begin
         q2_out = TAG_NONE;
         v2_out = cdb_data_s;
      end else begin
         q2_out = qi_arr[rs2_addr];
         v2_out = val_arr[rs2_addr];
      end
   end

   // Count pending registers as they will stand after this edge
   always_comb begin
      busy_d = 6'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_d = busy_d + {5'd0, (qi_nxt_arr[i] != TAG_NONE)};
      end
   end

   // Busy counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 6'd0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_count = busy_q;

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file. The driver applies one vector per
// cycle and pushes the hand-computed response into a scoreboard queue; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_reg_status_file;
   import tomasulo_pkg::*;

   logic        clk;
   logic        rst;
   logic [40:0] cdb;
   logic        issue;
   logic [4:0]  issue_rd;
   logic [7:0]  issue_tag;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [7:0]  q1_out;
   logic [31:0] v1_out;
   logic [7:0]  q2_out;
   logic [31:0] v2_out;
   logic [5:0]  busy_count;

   typedef struct {
      string       name;
      logic [7:0]  q1;
      logic [31:0] v1;
      logic [7:0]  q2;
      logic [31:0] v2;
      logic [5:0]  busy;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   reg_status_file dut (
      .clk        (clk),
      .rst        (rst),
      .cdb        (cdb),
      .issue      (issue),
      .issue_rd   (issue_rd),
      .issue_tag  (issue_tag),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .q1_out     (q1_out),
      .v1_out     (v1_out),
      .q2_out     (q2_out),
      .v2_out     (v2_out),
      .busy_count (busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issuing with tag zero is illegal stimulus
   always @(posedge clk) begin
      assert (!(issue && issue_tag == 8'h00))
         else $error("illegal issue with tag zero");
   end

   task automatic cmp(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s actual=%h expected=%h at %0t", nm, fld, act, exp, $time);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the rising edge
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         cmp(e.name, "q1",   {24'd0, q1_out},     {24'd0, e.q1});
         cmp(e.name, "v1",   v1_out,              e.v1);
         cmp(e.name, "q2",   {24'd0, q2_out},     {24'd0, e.q2});
         cmp(e.name, "v2",   v2_out,              e.v2);
         cmp(e.name, "busy", {26'd0, busy_count}, {26'd0, e.busy});
      end
   end

   task automatic push_exp(input string nm, input logic [7:0] eq1, input logic [31:0] ev1,
                           input logic [7:0] eq2, input logic [31:0] ev2, input logic [5:0] eb);
      exp_t e;
      e.name = nm; e.q1 = eq1; e.v1 = ev1; e.q2 = eq2; e.v2 = ev2; e.busy = eb;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic iss, input logic [4:0] rd, input logic [7:0] tg,
                        input logic cv, input logic [7:0] ct, input logic [31:0] cd,
                        input logic [4:0] a1, input logic [4:0] a2);
      issue = iss; issue_rd = rd; issue_tag = tg;
      cdb = {cv, ct, cd};
      rs1_addr = a1; rs2_addr = a2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full cycle: apply vector, record expected outputs, advance
   task automatic step(input string nm,
                       input logic iss, input logic [4:0] rd, input logic [7:0] tg,
                       input logic cv, input logic [7:0] ct, input logic [31:0] cd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [7:0] eq1, input logic [31:0] ev1,
                       input logic [7:0] eq2, input logic [31:0] ev2, input logic [5:0] eb);
      drive(iss, rd, tg, cv, ct, cd, a1, a2);
      push_exp(nm, eq1, ev1, eq2, ev2, eb);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: run did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd5, 5'd7);
      #1;
      step("reset", 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd5, 5'd7,
           8'h00, 32'd0, 8'h00, 32'd0, 6'd0);
      rst = 1'b0;

      // Rename and retire with bypass
      step("ren_r3",    1'b1, 5'd3, 8'h41, 1'b0, 8'h00, 32'd0, 5'd3, 5'd0,
           8'h00, 32'd0, 8'h00, 32'd0, 6'd0);
      step("pend_r3",   1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd3, 5'd0,
           8'h41, 32'd0, 8'h00, 32'd0, 6'd1);
      step("byp_r3",    1'b0, 5'd0, 8'h00, 1'b1, 8'h41, 32'd6, 5'd3, 5'd0,
           8'h00, 32'd6, 8'h00, 32'd0, 6'd1);
      step("ret_r3",    1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd3, 5'd5,
           8'h00, 32'd6, 8'h00, 32'd0, 6'd0);

      // Two waiters on one tag
      step("ren_r2",    1'b1, 5'd2, 8'h42, 1'b0, 8'h00, 32'd0, 5'd2, 5'd4,
           8'h00, 32'd0, 8'h00, 32'd0, 6'd0);
      step("ren_r4",    1'b1, 5'd4, 8'h42, 1'b0, 8'h00, 32'd0, 5'd2, 5'd4,
           8'h42, 32'd0, 8'h00, 32'd0, 6'd1);
      step("byp_r2r4",  1'b0, 5'd0, 8'h00, 1'b1, 8'h42, 32'd20, 5'd2, 5'd4,
           8'h00, 32'd20, 8'h00, 32'd20, 6'd2);
      step("ret_r2r4",  1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd2, 5'd4,
           8'h00, 32'd20, 8'h00, 32'd20, 6'd0);

      // Rename and retire on the same register in the same edge
      step("ren_r6a",   1'b1, 5'd6, 8'h41, 1'b0, 8'h00, 32'd0, 5'd6, 5'd3,
           8'h00, 32'd0, 8'h00, 32'd6, 6'd0);
      step("ren_ret_r6",1'b1, 5'd6, 8'h43, 1'b1, 8'h41, 32'd9, 5'd6, 5'd6,
           8'h00, 32'd9, 8'h00, 32'd9, 6'd1);
      step("r6_newtag", 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd6, 5'd3,
           8'h43, 32'd9, 8'h00, 32'd6, 6'd1);
      step("byp_r6",    1'b0, 5'd0, 8'h00, 1'b1, 8'h43, 32'd15, 5'd6, 5'd3,
           8'h00, 32'd15, 8'h00, 32'd6, 6'd1);
      step("ret_r6",    1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd6, 5'd2,
           8'h00, 32'd15, 8'h00, 32'd20, 6'd0);

      // Reads see pre-rename state
      step("ren_r1a",   1'b1, 5'd1, 8'h46, 1'b0, 8'h00, 32'd0, 5'd1, 5'd0,
           8'h00, 32'd0, 8'h00, 32'd0, 6'd0);
      step("byp_r1",    1'b0, 5'd0, 8'h00, 1'b1, 8'h46, 32'd2, 5'd1, 5'd0,
           8'h00, 32'd2, 8'h00, 32'd0, 6'd1);
      step("ren_r1b",   1'b1, 5'd1, 8'h44, 1'b0, 8'h00, 32'd0, 5'd1, 5'd1,
           8'h00, 32'd2, 8'h00, 32'd2, 6'd0);
      step("r1_pend",   1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd1, 5'd3,
           8'h44, 32'd2, 8'h00, 32'd6, 6'd1);

      // r0 rename and tag-zero / invalid broadcasts are ignored
      step("r0_ign",    1'b1, 5'd0, 8'h45, 1'b1, 8'h00, 32'd99, 5'd0, 5'd1,
           8'h00, 32'd0, 8'h44, 32'd2, 6'd1);
      step("inv_cdb",   1'b0, 5'd0, 8'h00, 1'b0, 8'h44, 32'd77, 5'd0, 5'd1,
           8'h00, 32'd0, 8'h44, 32'd2, 6'd1);
      step("after_ign", 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd1, 5'd3,
           8'h44, 32'd2, 8'h00, 32'd6, 6'd1);

      // Build up pending renames, then reset mid-cycle
      step("ren_r7",    1'b1, 5'd7, make_tag(UNIT_LS, 3'd7), 1'b0, 8'h00, 32'd0, 5'd7, 5'd1,
           8'h00, 32'd0, 8'h44, 32'd2, 6'd1);
      step("ren_r8",    1'b1, 5'd8, 8'h48, 1'b0, 8'h00, 32'd0, 5'd7, 5'd1,
           8'h17, 32'd0, 8'h44, 32'd2, 6'd2);
      step("ren_r9",    1'b1, 5'd9, 8'h49, 1'b0, 8'h00, 32'd0, 5'd8, 5'd9,
           8'h48, 32'd0, 8'h00, 32'd0, 6'd3);
      step("pend4",     1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd7, 5'd9,
           8'h17, 32'd0, 8'h49, 32'd0, 6'd4);

      drive(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd7, 5'd1);
      #2;
      rst = 1'b1;
      push_exp("mid_rst", 8'h00, 32'd0, 8'h00, 32'd0, 6'd0);
      tick();
      rst = 1'b0;
      step("post_rst",  1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd6, 5'd9,
           8'h00, 32'd0, 8'h00, 32'd0, 6'd0);
      step("post_rst2", 1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 32'd0, 5'd3, 5'd2,
           8'h00, 32'd0, 8'h00, 32'd0, 6'd0);

      tick();
      cmp("sb_drain", "left", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus register result-status (Qi) table.
- Snoops the common data bus as a reader. Functional units drive the bus through common_data_bus; this block retires their broadcasts into registers.
- Supplies operand tag/value pairs (q1/v1, q2/v2) to the issue stage and records the destination tag of each issued instruction (renaming).
- Sits between the instruction issue logic and the reservation-station units.

Parameters:
- NUM_REGS, 32, number of architectural registers (index 0 hardwired zero).
- ADDR_W, 5, register index width.
- TAG_W, 8, reservation-station tag width: 5-bit unit field, 3-bit station index.
- DATA_W, 32, register value width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cdb  in  41  common data bus: [40] valid, [39:32] tag, [31:0] value.
- issue  in  1  an instruction issues this cycle.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_tag  in  8  reservation-station tag that will produce issue_rd.
- rs1_addr  in  5  source register 1 index.
- rs2_addr  in  5  source register 2 index.
- q1_out  out  8  producer tag for rs1; 0 means value ready.
- v1_out  out  32  value of rs1, valid when q1_out==0.
- q2_out  out  8  producer tag for rs2.
- v2_out  out  32  value of rs2.
- busy_count  out  6  number of registers currently holding a non-zero tag.

Behaviour:
- Storage: per register, Qi[TAG_W] and value[DATA_W]. Tag 8'h00 means no pending producer.
- Reset (async, any time, including mid-operation): all Qi=0, all values=0, busy_count=0. Read outputs then show q=0, v=0 for every address.
- CDB retire (rising edge): when cdb[40]=1 and cdb tag!=0, every register whose Qi equals the cdb tag loads the cdb value and sets Qi=0, all in the same edge.
  - Multiple waiters on one tag all update.
  - A broadcast with tag 0, or with valid=0, changes nothing.
- Rename (rising edge): when issue=1 and issue_rd!=0, Qi[issue_rd] <= issue_tag and the value is unchanged.
  - issue_rd==0 is ignored; r0 stays Qi=0, value=0 forever.
  - issue_tag==0 with issue=1 is illegal. The block ignores it, and the bench asserts it never occurs.
- Simultaneous rename and retire on the same register: the rename wins for Qi. The value still loads from the cdb if the old Qi matched.
- Read ports are combinational, one per source:
  - If Qi[rs]!=0, cdb valid and cdb tag==Qi[rs], output q=0 and v=cdb value (same-cycle bypass).
  - Otherwise output q=Qi[rs] and v=value[rs].
  - Reads see pre-rename state. A same-cycle issue to rs does not affect the outputs, so r1=r1*r2 sees r1's old producer.
  - rs==0 always gives q=0, v=0.
- busy_count: registered. Updated each edge to the count of non-zero Qi after that edge's retire and rename. Range 0..31.
- No stall output; the table never fills. Up to one rename and one retire per cycle.

Decomposition:
- Shared package tomasulo_pkg holds:
  - CDB field positions: CDB_VALID=40, CDB_TAG_HI=39, CDB_TAG_LO=32, CDB_DATA_HI=31.
  - TAG_NONE=8'h00.
  - Unit-field codes for ALU/mul/div/ls tags, such as 5'b01000 for mul.
  - Widths TAG_W, DATA_W, ADDR_W.
- One sub-module is natural: reg_status_entry, a single register's Qi/value with retire/rename priority logic. It is instantiated 31 times, with r0 as constant zero.
- Read muxes, bypass and busy_count live in the top.

Test Plan:
- Reset then read r5/r7 -> q1_out=0, v1_out=0, q2_out=0, v2_out=0, busy_count=0. Assert rst mid-run with 3 renamed regs -> all Qi clear immediately, without waiting for a clock edge.
- Issue rd=3, tag=8'h41; next cycle read rs1=3 -> q1_out=8'h41, busy_count=1. Broadcast cdb={1,8'h41,32'd6} -> same cycle q1_out=0, v1_out=6 (bypass). After the edge, value[3]=6, busy_count=0.
- Rename r2 and r4 both to tag 8'h42; broadcast {1,8'h42,32'd20} -> both r2 and r4 read q=0, v=20.
- r6 pending on tag 8'h41; same cycle issue rd=6 tag=8'h43 and cdb {1,8'h41,32'd9} -> Qi[6]=8'h43, value[6]=9. A later broadcast of 8'h43 with 32'd15 -> v=15.
- Issue rd=1 tag=8'h44 while rs1=1 and r1 ready with value 2 -> the same-cycle read gives q1_out=0, v1_out=2. The next cycle gives q1_out=8'h44.
- Issue rd=0 tag=8'h45, and broadcast {1,8'h00,32'd99} -> r0 reads 0/0, no register changes, busy_count unchanged.
